// File: rtl/freq_pkg.sv
// freq_pkg: shared types and default constants for the SWIPT frequency sweep.
//   sweep_state_t : scheduler states (IDLE, SETTLE, SAMPLE, EVAL, APPLY, DONE)
//   FREQ_W/ADC_W  : frequency word and ADC sample widths
//   DEF_*         : default parameter values (settle = 2 ms at 100 MHz)
package freq_pkg;

    localparam int FREQ_W = 20;
    localparam int ADC_W  = 12;

    localparam logic [FREQ_W-1:0] DEF_F_START     = 20'd80000;
    localparam logic [FREQ_W-1:0] DEF_F_STOP      = 20'd120000;
    localparam logic [FREQ_W-1:0] DEF_F_STEP      = 20'd1000;
    localparam logic [23:0]       DEF_SETTLE_CYC  = 24'h30D40;
    localparam int                DEF_AVG_LOG2    = 4;
    localparam logic [31:0]       DEF_RESWEEP_CYC = 32'd100_000_000;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        EVAL,
        APPLY,
        DONE
    } sweep_state_t;

endpackage

// File: rtl/adc_block_avg.sv
// adc_block_avg: accumulates 2^AVG_LOG2 qualified ADC samples and reports
// their floor average with a one-cycle avg_valid pulse.
//   clk, nrst  : clock, asynchronous active-low reset
//   clr        : restart the block (drops any partial accumulation)
//   sample_en  : count adc this cycle
//   adc        : ADC sample
//   avg        : average of the last completed block (held until the next)
//   avg_valid  : one-cycle pulse the cycle after the last sample of a block
module adc_block_avg
    import freq_pkg::*;
#(
    parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             clr,
    input  logic             sample_en,
    input  logic [ADC_W-1:0] adc,
    output logic [ADC_W-1:0] avg,
    output logic             avg_valid
);

    // Wide enough for 2^AVG_LOG2 full-scale samples, so the sum never wraps.
    localparam int ACC_W = ADC_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic [CNT_W-1:0] cnt;

    assign acc_sum = acc + ACC_W'(adc);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            acc       <= '0;
            cnt       <= '0;
            avg       <= '0;
            avg_valid <= 1'b0;
        end else if (clr) begin
            acc       <= '0;
            cnt       <= '0;
            avg_valid <= 1'b0;
        end else begin
            // NOTE: state updates use <= so every flop sees pre-edge values.
            avg_valid <= 1'b0;
            if (sample_en) begin
                if (cnt == LAST) begin
                    avg       <= acc_sum[ACC_W-1:AVG_LOG2];
                    avg_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/freq_sweep_ctrl.sv
// freq_sweep_ctrl: steps the SWIPT drive frequency F_START..F_STOP by F_STEP,
// settles, averages an ADC block per step, and applies the frequency with the
// highest average (lowest frequency wins ties) when the sweep completes.
//   clk, nrst  : clock, asynchronous active-low reset
//   swiptAlive : link up; low aborts any sweep
//   sweepReq   : starts a sweep when sampled in IDLE
//   ADC        : ADC sample, qualified by adcValid
//   freqOut    : frequency driven to the generator
//   bestFreq   : best frequency of the last completed sweep
//   bestADC    : average ADC at bestFreq
//   sweepBusy  : high from SETTLE entry until the cycle before DONE
//   sweepDone  : one-cycle pulse when bestFreq is applied
// Optional: define FREQ_SWEEP_AUTORESWEEP_EN to re-sweep RESWEEP_CYC idle
// cycles after each completed sweep.
module freq_sweep_ctrl
    import freq_pkg::*;
#(
    parameter logic [FREQ_W-1:0] F_START    = DEF_F_START,
    parameter logic [FREQ_W-1:0] F_STOP     = DEF_F_STOP,
    parameter logic [FREQ_W-1:0] F_STEP     = DEF_F_STEP,
    parameter logic [23:0]       SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int                AVG_LOG2   = DEF_AVG_LOG2
`ifdef FREQ_SWEEP_AUTORESWEEP_EN
    ,
    parameter logic [31:0]       RESWEEP_CYC = DEF_RESWEEP_CYC
`endif
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              swiptAlive,
    input  logic              sweepReq,
    input  logic [ADC_W-1:0]  ADC,
    input  logic              adcValid,
    output logic [FREQ_W-1:0] freqOut,
    output logic [FREQ_W-1:0] bestFreq,
    output logic [ADC_W-1:0]  bestADC,
    output logic              sweepBusy,
    output logic              sweepDone
);

    sweep_state_t      state_q, state_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic [23:0]       settle_q, settle_d;
    logic [ADC_W-1:0]  run_best_q, run_best_d;
    logic [FREQ_W-1:0] run_best_freq_q, run_best_freq_d;
    logic [FREQ_W-1:0] best_freq_q, best_freq_d;
    logic [ADC_W-1:0]  best_adc_q, best_adc_d;
`ifdef FREQ_SWEEP_AUTORESWEEP_EN
    logic [31:0]       timer_q, timer_d;
    logic              armed_q, armed_d;
`endif

    logic              start;
    logic              avg_clr;
    logic              sample_en;
    logic [ADC_W-1:0]  avg;
    logic              avg_valid;
    // One extra bit so stepping past the top of the 20-bit range cannot wrap.
    logic [FREQ_W:0]   nxt_freq;

    assign nxt_freq = {1'b0, freq_q} + {1'b0, F_STEP};

    adc_block_avg #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clk       (clk),
        .nrst      (nrst),
        .clr       (avg_clr),
        .sample_en (sample_en),
        .adc       (ADC),
        .avg       (avg),
        .avg_valid (avg_valid)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q         <= IDLE;
            freq_q          <= F_START;
            settle_q        <= '0;
            run_best_q      <= '0;
            run_best_freq_q <= F_START;
            best_freq_q     <= F_START;
            best_adc_q      <= '0;
`ifdef FREQ_SWEEP_AUTORESWEEP_EN
            timer_q         <= '0;
            armed_q         <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            freq_q          <= freq_d;
            settle_q        <= settle_d;
            run_best_q      <= run_best_d;
            run_best_freq_q <= run_best_freq_d;
            best_freq_q     <= best_freq_d;
            best_adc_q      <= best_adc_d;
`ifdef FREQ_SWEEP_AUTORESWEEP_EN
            timer_q         <= timer_d;
            armed_q         <= armed_d;
`endif
        end
    end

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path infers a latch.
        state_d         = state_q;
        freq_d          = freq_q;
        settle_d        = settle_q;
        run_best_d      = run_best_q;
        run_best_freq_d = run_best_freq_q;
        best_freq_d     = best_freq_q;
        best_adc_d      = best_adc_q;
        avg_clr         = 1'b0;
        sample_en       = 1'b0;
        start           = sweepReq;
`ifdef FREQ_SWEEP_AUTORESWEEP_EN
        timer_d         = timer_q;
        armed_d         = armed_q;
        // The idle timer only runs after a completed sweep (armed) and while the link is up.
        if (state_q == IDLE && armed_q && swiptAlive) begin
            if (timer_q <= 32'd1) begin
                start = 1'b1;
            end else begin
                timer_d = timer_q - 32'd1;
            end
        end
`endif

        if (state_q != IDLE && !swiptAlive) begin
            // Link loss wins over everything; completed results are kept.
            state_d = IDLE;
            freq_d  = F_START;
`ifdef FREQ_SWEEP_AUTORESWEEP_EN
            timer_d = '0;
            armed_d = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && swiptAlive) begin
                        state_d         = SETTLE;
                        freq_d          = F_START;
                        run_best_d      = '0;
                        run_best_freq_d = F_START;
                        settle_d        = SETTLE_CYC;
`ifdef FREQ_SWEEP_AUTORESWEEP_EN
                        armed_d         = 1'b0;
`endif
                    end
                end
                SETTLE: begin
                    if (settle_q == 24'd0) begin
                        avg_clr = 1'b1;
                        state_d = SAMPLE;
                    end else begin
                        settle_d = settle_q - 24'd1;
                    end
                end
                SAMPLE: begin
                    // Gate off samples once the block result is out, so nothing
                    // lands in the accumulator while moving to EVAL.
                    sample_en = adcValid && !avg_valid;
                    if (avg_valid) begin
                        state_d = EVAL;
                    end
                end
                EVAL: begin
                    if (avg > run_best_q) begin
                        run_best_d      = avg;
                        run_best_freq_d = freq_q;
                    end
                    if (nxt_freq > {1'b0, F_STOP}) begin
                        state_d = APPLY;
                    end else begin
                        freq_d   = nxt_freq[FREQ_W-1:0];
                        settle_d = SETTLE_CYC;
                        state_d  = SETTLE;
                    end
                end
                APPLY: begin
                    freq_d      = run_best_freq_q;
                    best_freq_d = run_best_freq_q;
                    best_adc_d  = run_best_q;
                    state_d     = DONE;
                end
                DONE: begin
                    state_d = IDLE;
`ifdef FREQ_SWEEP_AUTORESWEEP_EN
                    timer_d = RESWEEP_CYC;
                    armed_d = 1'b1;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign freqOut   = freq_q;
    assign bestFreq  = best_freq_q;
    assign bestADC   = best_adc_q;
    assign sweepBusy = state_q inside {SETTLE, SAMPLE, EVAL, APPLY};
    assign sweepDone = (state_q == DONE);

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// tb_freq_sweep_ctrl: directed bench for freq_sweep_ctrl with a small sweep
// (100..130 step 10, settle 4, two samples per average). Each step takes
// 9 cycles from SETTLE entry: 5 settle, 2 samples, 1 result, 1 EVAL.
// Define FREQ_SWEEP_AUTORESWEEP_EN to also exercise the idle re-sweep.
module tb_freq_sweep_ctrl;
    import freq_pkg::*;

    logic        clk;
    logic        nrst;
    logic        swiptAlive;
    logic        sweepReq;
    logic [11:0] ADC;
    logic        adcValid;
    logic [19:0] freqOut;
    logic [19:0] bestFreq;
    logic [11:0] bestADC;
    logic        sweepBusy;
    logic        sweepDone;

    int total = 0;
    int bad   = 0;

    freq_sweep_ctrl #(
        .F_START    (20'd100),
        .F_STOP     (20'd130),
        .F_STEP     (20'd10),
        .SETTLE_CYC (24'd4),
        .AVG_LOG2   (1)
`ifdef FREQ_SWEEP_AUTORESWEEP_EN
        ,
        .RESWEEP_CYC (32'd20)
`endif
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .swiptAlive (swiptAlive),
        .sweepReq   (sweepReq),
        .ADC        (ADC),
        .adcValid   (adcValid),
        .freqOut    (freqOut),
        .bestFreq   (bestFreq),
        .bestADC    (bestADC),
        .sweepBusy  (sweepBusy),
        .sweepDone  (sweepDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // 5 SETTLE cycles with junk on the ADC that must be ignored.
    task automatic settle_phase();
        adcValid = 1'b1;
        ADC      = 12'd4095;
        repeat (5) step();
    endtask

    // Two samples, then the result cycle and EVAL; ends on the next state.
    task automatic sample_pair(input logic [11:0] a0, input logic [11:0] a1);
        adcValid = 1'b1;
        ADC      = a0;
        step();
        ADC      = a1;
        step();
        adcValid = 1'b0;
        step();
        step();
    endtask

    task automatic do_step(input string tag, input logic [19:0] f,
                           input logic [11:0] a0, input logic [11:0] a1);
        check({tag, "_freq"}, 32'(freqOut), 32'(f));
        check({tag, "_busy"}, 32'(sweepBusy), 32'd1);
        settle_phase();
        sample_pair(a0, a1);
    endtask

    // Called in APPLY; checks the DONE pulse and the applied result.
    task automatic finish_sweep(input string tag, input logic [19:0] bf, input logic [11:0] badc);
        sweepReq = 1'b0;
        check({tag, "_apply_busy"}, 32'(sweepBusy), 32'd1);
        check({tag, "_apply_done"}, 32'(sweepDone), 32'd0);
        step();
        check({tag, "_done_pulse"}, 32'(sweepDone), 32'd1);
        check({tag, "_done_busy"}, 32'(sweepBusy), 32'd0);
        check({tag, "_done_freq"}, 32'(freqOut), 32'(bf));
        check({tag, "_best_freq"}, 32'(bestFreq), 32'(bf));
        check({tag, "_best_adc"}, 32'(bestADC), 32'(badc));
        step();
        check({tag, "_idle_done"}, 32'(sweepDone), 32'd0);
        check({tag, "_idle_busy"}, 32'(sweepBusy), 32'd0);
        check({tag, "_idle_freq"}, 32'(freqOut), 32'(bf));
    endtask

    initial begin
        nrst       = 1'b0;
        swiptAlive = 1'b1;
        sweepReq   = 1'b0;
        ADC        = '0;
        adcValid   = 1'b0;
        repeat (2) step();
        nrst = 1'b1;
        step();

        // Reset state.
        check("rst_freq", 32'(freqOut), 32'd100);
        check("rst_best_freq", 32'(bestFreq), 32'd100);
        check("rst_best_adc", 32'(bestADC), 32'd0);
        check("rst_busy", 32'(sweepBusy), 32'd0);
        check("rst_done", 32'(sweepDone), 32'd0);

        // 1: averages 50/200/120/80 -> 110 wins.
        sweepReq = 1'b1;
        step();
        sweepReq = 1'b0;
        do_step("t1_100", 20'd100, 12'd49, 12'd51);
        do_step("t1_110", 20'd110, 12'd200, 12'd200);
        do_step("t1_120", 20'd120, 12'd119, 12'd121);
        do_step("t1_130", 20'd130, 12'd80, 12'd81);
        check("t1_apply_freq", 32'(freqOut), 32'd130);
        finish_sweep("t1", 20'd110, 12'd200);

        // 2: tie at 150 between 110 and 120 -> lower frequency kept.
        sweepReq = 1'b1;
        step();
        sweepReq = 1'b0;
        do_step("t2_100", 20'd100, 12'd90, 12'd90);
        do_step("t2_110", 20'd110, 12'd150, 12'd150);
        do_step("t2_120", 20'd120, 12'd149, 12'd151);
        do_step("t2_130", 20'd130, 12'd10, 12'd11);
        finish_sweep("t2", 20'd110, 12'd150);

        // 3: link drop during SAMPLE at 120.
        sweepReq = 1'b1;
        step();
        sweepReq = 1'b0;
        do_step("t3_100", 20'd100, 12'd60, 12'd60);
        do_step("t3_110", 20'd110, 12'd700, 12'd700);
        check("t3_120_freq", 32'(freqOut), 32'd120);
        settle_phase();
        ADC = 12'd30;
        step();
        swiptAlive = 1'b0;
        step();
        check("t3_abort_busy", 32'(sweepBusy), 32'd0);
        check("t3_abort_freq", 32'(freqOut), 32'd100);
        check("t3_abort_done", 32'(sweepDone), 32'd0);
        check("t3_abort_best_freq", 32'(bestFreq), 32'd110);
        check("t3_abort_best_adc", 32'(bestADC), 32'd150);
        check("t3_abort_state", 32'(dut.state_q), 32'(IDLE));
        sweepReq = 1'b1;
        adcValid = 1'b0;
        step();
        check("t3_dead_link_no_start", 32'(sweepBusy), 32'd0);
        check("t3_no_late_done", 32'(sweepDone), 32'd0);
        sweepReq   = 1'b0;
        swiptAlive = 1'b1;
        step();

        // 4: stalled ADC holds SAMPLE, then full-scale samples average cleanly.
        sweepReq = 1'b1;
        step();
        sweepReq = 1'b0;
        check("t4_100_freq", 32'(freqOut), 32'd100);
        settle_phase();
        adcValid = 1'b0;
        repeat (50) step();
        check("t4_stall_state", 32'(dut.state_q), 32'(SAMPLE));
        check("t4_stall_busy", 32'(sweepBusy), 32'd1);
        check("t4_stall_freq", 32'(freqOut), 32'd100);
        sample_pair(12'd4095, 12'd4095);
        do_step("t4_110", 20'd110, 12'd4095, 12'd4094);
        do_step("t4_120", 20'd120, 12'd0, 12'd1);
        do_step("t4_130", 20'd130, 12'd5, 12'd5);
        finish_sweep("t4", 20'd100, 12'd4095);

        // 5: asynchronous reset mid-SETTLE at 110, between clock edges.
        sweepReq = 1'b1;
        step();
        sweepReq = 1'b0;
        do_step("t5_100", 20'd100, 12'd10, 12'd10);
        check("t5_110_freq", 32'(freqOut), 32'd110);
        step();
        step();
        #3;
        nrst = 1'b0;
        #1;
        check("t5_rst_freq", 32'(freqOut), 32'd100);
        check("t5_rst_busy", 32'(sweepBusy), 32'd0);
        check("t5_rst_done", 32'(sweepDone), 32'd0);
        check("t5_rst_best_adc", 32'(bestADC), 32'd0);
        check("t5_rst_best_freq", 32'(bestFreq), 32'd100);
        check("t5_rst_state", 32'(dut.state_q), 32'(IDLE));
        #2;
        nrst     = 1'b1;
        adcValid = 1'b0;
        step();

        // 5b: sweepReq held high through a sweep does not disturb the steps.
        sweepReq = 1'b1;
        step();
        do_step("t5_hold_100", 20'd100, 12'd10, 12'd10);
        do_step("t5_hold_110", 20'd110, 12'd20, 12'd20);
        do_step("t5_hold_120", 20'd120, 12'd30, 12'd30);
        do_step("t5_hold_130", 20'd130, 12'd40, 12'd40);
        finish_sweep("t5", 20'd130, 12'd40);

`ifdef FREQ_SWEEP_AUTORESWEEP_EN
        // 6: re-sweep on the 20th idle cycle after DONE, no sweepReq.
        repeat (19) step();
        check("t6_still_idle", 32'(sweepBusy), 32'd0);
        step();
        check("t6_auto_busy", 32'(sweepBusy), 32'd1);
        check("t6_auto_freq", 32'(freqOut), 32'd100);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
